dmem_ctrl: RTL and testbench

Parametrised data-memory controller between the CPU's data port and an internal word array. It replaces fixed base-subtract-and-divide addressing with a handshake-based, multi-cycle controller. It adds byte, half and word accesses, sign/zero extension on loads, configurable access latency, and fault reporting for out-of-range or misaligned addresses. It sits beside the instruction memory in the single-cycle/multi-cycle top level.

---
 rtl/dmem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: handshake-based data-memory controller between the CPU data port
// and an internal word array. Supports byte/half/word accesses, sign/zero
// extension on loads, configurable access latency and fault reporting for
// misaligned or out-of-range addresses.
// Optional feature macro: DMEM_CTRL_STATS_EN adds saturating access counters
// (rd_count, wr_count, flt_count).
module dmem_ctrl #(
    parameter int          DEPTH     = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int          LATENCY   = 1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        fault,
    output logic        busy
`ifdef DMEM_CTRL_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] flt_count
`endif
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int          CW   = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            ack_q, ack_d;
    logic            fault_q, fault_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            sext_q, sext_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      lane_q, lane_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            pend_flt_q, pend_flt_d;

    logic [31:0]     mem_q [DEPTH];

    logic [31:0]     offset_s;
    logic            req_flt_s;
    logic [31:0]     rd_word_s;
    logic [7:0]      rd_byte_s;
    logic [15:0]     rd_half_s;
    logic [31:0]     load_val_s;
    logic [3:0]      wr_be_s;
    logic [31:0]     wr_data_s;
    logic            mem_we_s;

`ifdef DMEM_CTRL_STATS_EN
    logic [31:0]     rd_cnt_q, rd_cnt_d;
    logic [31:0]     wr_cnt_q, wr_cnt_d;
    logic [31:0]     flt_cnt_q, flt_cnt_d;
`endif

    // Decode the incoming request: byte offset from the base and fault conditions
    always_comb begin
        offset_s  = addr - BASE_ADDR;
        req_flt_s = 1'b0;
        if (size == 2'b11) begin
            req_flt_s = 1'b1;
        end else if ((size == 2'b01) && addr[0]) begin
            req_flt_s = 1'b1;
        end else if ((size == 2'b10) && (addr[1:0] != 2'b00)) begin
            req_flt_s = 1'b1;
        end else if ({1'b0, offset_s} >= SPAN) begin
            req_flt_s = 1'b1;
        end else begin
            req_flt_s = 1'b0;
        end
    end

    // Extract and extend the addressed byte/half of the latched word for loads
    always_comb begin
        rd_word_s = mem_q[idx_q];
        case (lane_q)
            2'b00:   rd_byte_s = rd_word_s[7:0];
            2'b01:   rd_byte_s = rd_word_s[15:8];
            2'b10:   rd_byte_s = rd_word_s[23:16];
            2'b11:   rd_byte_s = rd_word_s[31:24];
            default: rd_byte_s = 8'h00;
        endcase
        if (lane_q[1]) begin
            rd_half_s = rd_word_s[31:16];
        end else begin
            rd_half_s = rd_word_s[15:0];
        end
        case (size_q)
            2'b00:   load_val_s = sext_q ? {{24{rd_byte_s[7]}}, rd_byte_s}
                                         : {24'h000000, rd_byte_s};
            2'b01:   load_val_s = sext_q ? {{16{rd_half_s[15]}}, rd_half_s}
                                         : {16'h0000, rd_half_s};
            default: load_val_s = rd_word_s;
        endcase
    end

    // Build lane enables and lane-replicated store data from the latched request
    always_comb begin
        case (size_q)
            2'b00: begin
                wr_be_s   = 4'b0001 << lane_q;
                wr_data_s = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_be_s   = lane_q[1] ? 4'b1100 : 4'b0011;
                wr_data_s = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                wr_be_s   = 4'b1111;
                wr_data_s = wdata_q;
            end
            default: begin
                wr_be_s   = 4'b0000;
                wr_data_s = 32'h00000000;
            end
        endcase
    end

    // Next-state and output logic for the IDLE/WAIT/RESP handshake
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        fault_d    = 1'b0;
        rdata_d    = rdata_q;
        we_d       = we_q;
        size_d     = size_q;
        sext_d     = sext_q;
        idx_d      = idx_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        pend_flt_d = pend_flt_q;
        mem_we_s   = 1'b0;
`ifdef DMEM_CTRL_STATS_EN
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        flt_cnt_d  = flt_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d       = we;
                    size_d     = size;
                    sext_d     = sign_ext;
                    idx_d      = offset_s[AW+1:2];
                    lane_d     = offset_s[1:0];
                    wdata_d    = wdata;
                    pend_flt_d = req_flt_s;
                    busy_d     = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 2);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                ack_d   = 1'b1;
                fault_d = pend_flt_q;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (pend_flt_q) begin
`ifdef DMEM_CTRL_STATS_EN
                    if (flt_cnt_q != 32'hFFFFFFFF) flt_cnt_d = flt_cnt_q + 32'd1;
                    else flt_cnt_d = flt_cnt_q;
`endif
                end else if (we_q) begin
                    mem_we_s = 1'b1;
`ifdef DMEM_CTRL_STATS_EN
                    if (wr_cnt_q != 32'hFFFFFFFF) wr_cnt_d = wr_cnt_q + 32'd1;
                    else wr_cnt_d = wr_cnt_q;
`endif
                end else begin
                    rdata_d = load_val_s;
`ifdef DMEM_CTRL_STATS_EN
                    if (rd_cnt_q != 32'hFFFFFFFF) rd_cnt_d = rd_cnt_q + 32'd1;
                    else rd_cnt_d = rd_cnt_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and output registers; reset aborts any access in flight
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            fault_q    <= 1'b0;
            rdata_q    <= 32'h00000000;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sext_q     <= 1'b0;
            idx_q      <= {AW{1'b0}};
            lane_q     <= 2'b00;
            wdata_q    <= 32'h00000000;
            pend_flt_q <= 1'b0;
`ifdef DMEM_CTRL_STATS_EN
            rd_cnt_q   <= 32'h00000000;
            wr_cnt_q   <= 32'h00000000;
            flt_cnt_q  <= 32'h00000000;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            fault_q    <= fault_d;
            rdata_q    <= rdata_d;
            we_q       <= we_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
            pend_flt_q <= pend_flt_d;
`ifdef DMEM_CTRL_STATS_EN
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            flt_cnt_q  <= flt_cnt_d;
`endif
        end
    end

    // Array write with per-lane enables; contents are deliberately not reset
    always_ff @(posedge clk_in) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_s[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign fault = fault_q;
    assign busy  = busy_q;
`ifdef DMEM_CTRL_STATS_EN
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign flt_count = flt_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl: one instance at LATENCY=1, one at LATENCY=4.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst1, rst4;
    logic        req1, we1, sx1, req4, we4, sx4;
    logic [1:0]  sz1, sz4;
    logic [31:0] a1, wd1, a4, wd4;
    logic [31:0] rdata1, rdata4;
    logic        ack1, fault1, busy1, ack4, fault4, busy4;
`ifdef DMEM_CTRL_STATS_EN
    logic [31:0] rc1, wc1, fc1, rc4, wc4, fc4;
`endif

    int total = 0;
    int bad   = 0;

    dmem_ctrl #(.DEPTH(2048), .BASE_ADDR(32'h10010000), .LATENCY(1)) u_dut1 (
        .clk_in(clk), .reset(rst1), .req(req1), .we(we1), .size(sz1),
        .sign_ext(sx1), .addr(a1), .wdata(wd1), .rdata(rdata1), .ack(ack1),
        .fault(fault1), .busy(busy1)
`ifdef DMEM_CTRL_STATS_EN
        , .rd_count(rc1), .wr_count(wc1), .flt_count(fc1)
`endif
    );

    dmem_ctrl #(.DEPTH(2048), .BASE_ADDR(32'h10010000), .LATENCY(4)) u_dut4 (
        .clk_in(clk), .reset(rst4), .req(req4), .we(we4), .size(sz4),
        .sign_ext(sx4), .addr(a4), .wdata(wd4), .rdata(rdata4), .ack(ack4),
        .fault(fault4), .busy(busy4)
`ifdef DMEM_CTRL_STATS_EN
        , .rd_count(rc4), .wr_count(wc4), .flt_count(fc4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access on instance sel (1 or 4); returns rdata/fault at the ack and
    // the number of edges from accept to ack (-1 if no ack within the bound).
    task automatic access(input int sel, input logic w, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic flt, output int lat);
        int n;
        logic got;
        @(negedge clk);
        if (sel == 1) begin
            we1 = w; sz1 = sz; sx1 = sx; a1 = a; wd1 = wd; req1 = 1'b1;
        end else begin
            we4 = w; sz4 = sz; sx4 = sx; a4 = a; wd4 = wd; req4 = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0;
        req4 = 1'b0;
        n = 0;
        got = 1'b0;
        rd = 32'h0;
        flt = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if ((sel == 1) ? ack1 : ack4) begin
                got = 1'b1;
                rd  = (sel == 1) ? rdata1 : rdata4;
                flt = (sel == 1) ? fault1 : fault4;
            end
        end
        lat = got ? n : -1;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst4 = 1'b1;
        req1 = 1'b0; we1 = 1'b0; sz1 = 2'b00; sx1 = 1'b0; a1 = 32'h0; wd1 = 32'h0;
        req4 = 1'b0; we4 = 1'b0; sz4 = 2'b00; sx4 = 1'b0; a4 = 32'h0; wd4 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({rdata1, ack1, fault1, busy1} !== 35'h0) begin
            bad++; $display("FAIL reset_l1: got %h want 0", {rdata1, ack1, fault1, busy1});
        end
        total++;
        if ({rdata4, ack4, fault4, busy4} !== 35'h0) begin
            bad++; $display("FAIL reset_l4: got %h want 0", {rdata4, ack4, fault4, busy4});
        end
        @(negedge clk);
        rst1 = 1'b0; rst4 = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic flt; int lat;
        access(1, 1'b1, 2'b10, 1'b0, 32'h10010008, 32'hDEADBEEF, rd, flt, lat);
        total++;
        if (lat !== 1 || flt !== 1'b0) begin
            bad++; $display("FAIL word_store: lat %0d fault %b, want lat 1 fault 0", lat, flt);
        end
        access(1, 1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0, rd, flt, lat);
        total++;
        if (lat !== 1 || flt !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL word_load: lat %0d fault %b rdata %h, want 1 0 deadbeef", lat, flt, rd);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic flt; int lat;
        access(1, 1'b1, 2'b00, 1'b0, 32'h10010009, 32'h12345680, rd, flt, lat);
        total++;
        if (lat !== 1 || flt !== 1'b0) begin
            bad++; $display("FAIL byte_store: lat %0d fault %b, want 1 0", lat, flt);
        end
        access(1, 1'b0, 2'b00, 1'b1, 32'h10010009, 32'h0, rd, flt, lat);
        total++;
        if (rd !== 32'hFFFFFF80) begin
            bad++; $display("FAIL byte_load_sext: got %h want ffffff80", rd);
        end
        access(1, 1'b0, 2'b00, 1'b0, 32'h10010009, 32'h0, rd, flt, lat);
        total++;
        if (rd !== 32'h00000080) begin
            bad++; $display("FAIL byte_load_zext: got %h want 00000080", rd);
        end
        access(1, 1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0, rd, flt, lat);
        total++;
        if (rd !== 32'hDEAD80EF) begin
            bad++; $display("FAIL byte_merge_word: got %h want dead80ef", rd);
        end
    endtask

    task automatic test_half_fault();
        logic [31:0] rd; logic flt; int lat;
        access(1, 1'b0, 2'b01, 1'b1, 32'h1001000A, 32'h0, rd, flt, lat);
        total++;
        if (rd !== 32'hFFFFDEAD || flt !== 1'b0) begin
            bad++; $display("FAIL half_load_sext: got %h fault %b want ffffdead 0", rd, flt);
        end
        access(1, 1'b0, 2'b01, 1'b0, 32'h10010008, 32'h0, rd, flt, lat);
        total++;
        if (rd !== 32'h000080EF) begin
            bad++; $display("FAIL half_load_zext: got %h want 000080ef", rd);
        end
        access(1, 1'b0, 2'b10, 1'b0, 32'h10010006, 32'h0, rd, flt, lat);
        total++;
        if (flt !== 1'b1 || lat !== 1 || rd !== 32'h000080EF) begin
            bad++; $display("FAIL misaligned_load: fault %b lat %0d rdata %h want 1 1 000080ef", flt, lat, rd);
        end
        @(posedge clk);
        #1;
        total++;
        if (fault1 !== 1'b0 || ack1 !== 1'b0) begin
            bad++; $display("FAIL fault_clear: fault %b ack %b want 0 0", fault1, ack1);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic flt; int lat;
        access(1, 1'b1, 2'b10, 1'b0, 32'h10010000, 32'h11111111, rd, flt, lat);
        access(1, 1'b1, 2'b10, 1'b0, 32'h10011FFC, 32'h22222222, rd, flt, lat);
        access(1, 1'b1, 2'b01, 1'b0, 32'h10010002, 32'hFFFF5AA5, rd, flt, lat);
        total++;
        if (flt !== 1'b0) begin
            bad++; $display("FAIL half_store: fault %b want 0", flt);
        end
        access(1, 1'b1, 2'b10, 1'b0, 32'h10012000, 32'hBADBAD00, rd, flt, lat);
        total++;
        if (flt !== 1'b1 || lat !== 1) begin
            bad++; $display("FAIL range_high: fault %b lat %0d want 1 1", flt, lat);
        end
        access(1, 1'b1, 2'b10, 1'b0, 32'h1000FFFC, 32'hBADBAD01, rd, flt, lat);
        total++;
        if (flt !== 1'b1) begin
            bad++; $display("FAIL range_low: fault %b want 1", flt);
        end
        access(1, 1'b1, 2'b01, 1'b0, 32'h10010001, 32'hBADBAD02, rd, flt, lat);
        total++;
        if (flt !== 1'b1) begin
            bad++; $display("FAIL half_misaligned: fault %b want 1", flt);
        end
        access(1, 1'b1, 2'b11, 1'b0, 32'h10010000, 32'hBADBAD03, rd, flt, lat);
        total++;
        if (flt !== 1'b1) begin
            bad++; $display("FAIL size_illegal: fault %b want 1", flt);
        end
        access(1, 1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0, rd, flt, lat);
        total++;
        if (rd !== 32'h5AA51111) begin
            bad++; $display("FAIL word0_readback: got %h want 5aa51111", rd);
        end
        access(1, 1'b0, 2'b10, 1'b0, 32'h10011FFC, 32'h0, rd, flt, lat);
        total++;
        if (rd !== 32'h22222222) begin
            bad++; $display("FAIL last_readback: got %h want 22222222", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic flt; int lat;
        logic exp_busy, exp_ack;
        @(negedge clk);
        we4 = 1'b1; sz4 = 2'b10; sx4 = 1'b0; a4 = 32'h10010010; wd4 = 32'hCAFEF00D;
        req4 = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            exp_busy = ((e % 5) != 0);
            exp_ack  = ((e % 5) == 0);
            total++;
            if (busy4 !== exp_busy || ack4 !== exp_ack) begin
                bad++; $display("FAIL b2b_edge%0d: busy %b ack %b want %b %b", e, busy4, ack4, exp_busy, exp_ack);
            end
        end
        @(negedge clk);
        req4 = 1'b0;
        access(4, 1'b0, 2'b10, 1'b0, 32'h10010010, 32'h0, rd, flt, lat);
        total++;
        if (lat !== 4 || rd !== 32'hCAFEF00D || flt !== 1'b0) begin
            bad++; $display("FAIL l4_load: lat %0d rdata %h fault %b want 4 cafef00d 0", lat, rd, flt);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic flt; int lat;
        logic seen;
        @(negedge clk);
        we4 = 1'b1; sz4 = 2'b10; a4 = 32'h10010010; wd4 = 32'h0BADF00D; req4 = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy4 !== 1'b1) begin
            bad++; $display("FAIL abort_accept: busy %b want 1", busy4);
        end
        @(negedge clk);
        req4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        #1;
        total++;
        if (busy4 !== 1'b0 || rdata4 !== 32'h0) begin
            bad++; $display("FAIL abort_async: busy %b rdata %h want 0 0", busy4, rdata4);
        end
`ifdef DMEM_CTRL_STATS_EN
        total++;
        if ({rc4, wc4, fc4} !== 96'h0) begin
            bad++; $display("FAIL stats_reset: got %h want 0", {rc4, wc4, fc4});
        end
`endif
        @(negedge clk);
        rst4 = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ack4) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL abort_no_ack: ack seen %b want 0", seen);
        end
        access(4, 1'b0, 2'b10, 1'b0, 32'h10010010, 32'h0, rd, flt, lat);
        total++;
        if (rd !== 32'hCAFEF00D) begin
            bad++; $display("FAIL abort_unchanged: got %h want cafef00d", rd);
        end
    endtask

`ifdef DMEM_CTRL_STATS_EN
    task automatic test_stats();
        logic [31:0] rd; logic flt; int lat;
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        access(4, 1'b1, 2'b10, 1'b0, 32'h10010020, 32'h01020304, rd, flt, lat);
        access(4, 1'b1, 2'b00, 1'b0, 32'h10010021, 32'h000000AA, rd, flt, lat);
        access(4, 1'b0, 2'b10, 1'b0, 32'h10010020, 32'h0, rd, flt, lat);
        access(4, 1'b0, 2'b00, 1'b0, 32'h10010021, 32'h0, rd, flt, lat);
        access(4, 1'b0, 2'b01, 1'b0, 32'h10010020, 32'h0, rd, flt, lat);
        access(4, 1'b0, 2'b10, 1'b0, 32'h10010022, 32'h0, rd, flt, lat);
        total++;
        if (rc4 !== 32'd3 || wc4 !== 32'd2 || fc4 !== 32'd1) begin
            bad++; $display("FAIL stats_counts: rd %0d wr %0d flt %0d want 3 2 1", rc4, wc4, fc4);
        end
        @(negedge clk);
        rst4 = 1'b1;
        #1;
        total++;
        if ({rc4, wc4, fc4} !== 96'h0) begin
            bad++; $display("FAIL stats_clear: got %h want 0", {rc4, wc4, fc4});
        end
        @(negedge clk);
        rst4 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half_fault();
        test_range();
        test_back_to_back();
        test_reset_abort();
`ifdef DMEM_CTRL_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
